// File: rtl/lifo_pkg.sv
// lifo_pkg: shared FSM states, op encodings and default sizing for lifo_arb
package lifo_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP = 1'b1;
  localparam int DW_DEF = 8;
  localparam int DEPTH_DEF = 8;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, pointer hands priority to the loser after each grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic prio;
  always_comb gnt = &req ? (prio ? 2'b10 : 2'b01) : req;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) prio <= 1'b0;
    else if (en && |req) prio <= gnt[0];
endmodule

// File: rtl/lifo_arb.sv
// lifo_arb: arbitrates two requesters onto a shared LIFO, one operation in flight at a time
module lifo_arb
  import lifo_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [1:0]    req_valid,
  input  logic [1:0]    req_op,
  input  logic [2*DW-1:0] req_data,
  output logic [1:0]    req_ready,
  output logic [1:0]    rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          push,
  output logic          pop,
  output logic [DW-1:0] din,
  input  logic [DW-1:0] dout,
  input  logic          empty,
  input  logic          full,
  output logic [LW-1:0] level
);
  state_t state;
  logic id, op, err;
  logic [DW-1:0] data;
  logic [1:0] gnt;
  rr_arb2 u_arb (.clk(clk), .rstn(rstn), .en(state == IDLE), .req(req_valid), .gnt(gnt));
  // dout is only valid after the pop edge, so the response data path stays combinational
  always_comb begin
    req_ready = state == IDLE && rstn ? gnt : 2'b00;
    push = state == EXEC && op == OP_PUSH && !full;
    pop = state == EXEC && op == OP_POP && !empty;
    din = push ? data : '0;
    rsp_valid = state == RESP ? (id ? 2'b10 : 2'b01) : 2'b00;
    rsp_err = state == RESP && err;
    rsp_data = state == RESP && op == OP_POP && !err ? dout : '0;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      id <= 1'b0;
      op <= 1'b0;
      data <= '0;
      err <= 1'b0;
      level <= '0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          id <= gnt[1];
          op <= req_op[gnt[1]];
          data <= req_data[(gnt[1] ? DW : 0) +: DW];
          state <= EXEC;
        end
        EXEC: begin
          err <= op == OP_PUSH ? full : empty;
          if (push && level != LW'(DEPTH)) level <= level + LW'(1);
          else if (pop && level != '0) level <= level - LW'(1);
          state <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lifo_arb.sv
// tb_lifo_arb: directed checks of lifo_arb against a behavioural LIFO
module tb_lifo_arb;
  logic clk, rstn;
  logic [1:0] req_valid, req_op, req_ready, rsp_valid;
  logic [15:0] req_data;
  logic [7:0] rsp_data, din, dout;
  logic rsp_err, push, pop, empty, full;
  logic [3:0] level;
  logic [7:0] mem [8];
  int cnt, passed, total;

  lifo_arb #(.DW(8), .DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .push(push), .pop(pop), .din(din), .dout(dout), .empty(empty), .full(full), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign empty = cnt == 0;
  assign full = cnt == 8;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt <= 0;
      dout <= '0;
    end else begin
      if (push) begin
        mem[cnt] <= din;
        cnt <= cnt + 1;
      end
      if (pop) begin
        dout <= mem[cnt-1];
        cnt <= cnt - 1;
      end
    end

  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", t, got, exp);
  endtask

  task automatic do_rst();
    @(negedge clk);
    rstn = 1'b0;
    req_valid = 2'b01;
    req_op = 2'b00;
    req_data = 16'h00AA;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_outs", {rsp_data, rsp_err, push, pop, din}, 0);
    chk("rst_level", level, 0);
    @(negedge clk);
    req_valid = 2'b00;
    rstn = 1'b1;
  endtask

  task automatic do_op(input logic [1:0] v, input logic [1:0] g, input logic o, input logic [15:0] d,
                       input logic e, input logic [7:0] rd, input int lv, input logic h);
    logic [7:0] wd;
    wd = g[1] ? d[15:8] : d[7:0];
    @(negedge clk);
    req_valid = v;
    req_op = {o, o};
    req_data = d;
    #1;
    chk("ready", req_ready, g);
    @(posedge clk);
    #1;
    if (!h) req_valid = 2'b00;
    chk("exec_ready", req_ready, 0);
    chk("push", push, !o && !e);
    chk("pop", pop, o && !e);
    chk("din", din, (!o && !e) ? wd : 8'h00);
    @(posedge clk);
    #1;
    chk("rsp_valid", rsp_valid, g);
    chk("rsp_err", rsp_err, e);
    chk("rsp_data", rsp_data, rd);
    chk("level", level, lv);
    @(posedge clk);
    #1;
    chk("rsp_once", rsp_valid, 0);
  endtask

  initial begin
    passed = 0;
    total = 0;
    rstn = 1'b0;
    req_valid = 2'b00;
    req_op = 2'b00;
    req_data = 16'h0000;
    do_rst();
    do_op(2'b01, 2'b01, 1'b1, 16'h0000, 1'b1, 8'h00, 0, 1'b0);
    do_rst();
    do_op(2'b01, 2'b01, 1'b0, 16'h0011, 1'b0, 8'h00, 1, 1'b0);
    do_op(2'b01, 2'b01, 1'b0, 16'h0022, 1'b0, 8'h00, 2, 1'b0);
    do_op(2'b10, 2'b10, 1'b1, 16'h0000, 1'b0, 8'h22, 1, 1'b0);
    do_op(2'b01, 2'b01, 1'b1, 16'h0000, 1'b0, 8'h11, 0, 1'b0);
    do_rst();
    for (int k = 0; k < 4; k++)
      do_op(2'b11, k[0] ? 2'b10 : 2'b01, 1'b0, {8'hB0 + 8'(k), 8'hA0 + 8'(k)}, 1'b0, 8'h00, k + 1, 1'b1);
    do_op(2'b10, 2'b10, 1'b1, 16'h0000, 1'b0, 8'hB3, 3, 1'b0);
    do_op(2'b01, 2'b01, 1'b1, 16'h0000, 1'b0, 8'hA2, 2, 1'b0);
    do_rst();
    for (int i = 1; i <= 8; i++)
      do_op(2'b01, 2'b01, 1'b0, {8'h00, 8'(i)}, 1'b0, 8'h00, i, 1'b0);
    do_op(2'b01, 2'b01, 1'b0, 16'h00FF, 1'b1, 8'h00, 8, 1'b0);
    do_op(2'b01, 2'b01, 1'b1, 16'h0000, 1'b0, 8'h08, 7, 1'b0);
    do_rst();
    @(negedge clk);
    req_valid = 2'b01;
    req_op = 2'b00;
    req_data = 16'h0033;
    #1;
    chk("abort_ready", req_ready, 2'b01);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk("abort_push", push, 1);
    chk("abort_din", din, 8'h33);
    rstn = 1'b0;
    #1;
    chk("abort_outs", {rsp_valid, rsp_data, rsp_err, push, pop, din}, 0);
    chk("abort_level", level, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_rsp", rsp_valid, 0);
    end
    do_op(2'b11, 2'b01, 1'b0, 16'hB044, 1'b0, 8'h00, 1, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lifo_arb.md
LIFO_ARB -- requirements
Module: lifo_arb

Interface
REQ-001 Parameter DW, default 8, data width of the shared LIFO and all requester data.
REQ-002 Parameter DEPTH, default 8, LIFO capacity; level counter width = $clog2(DEPTH+1).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  2  per-requester request pending (bit i = requester i).
REQ-006 req_op  input  2  per-requester op: 0 = push, 1 = pop.
REQ-007 req_data  input  2*DW  push data; requester i in bits [i*DW +: DW].
REQ-008 req_ready  output  2  one-hot grant pulse; request accepted when req_valid[i] && req_ready[i].
REQ-009 rsp_valid  output  2  one-hot one-cycle response strobe to the granted requester.
REQ-010 rsp_data  output  DW  popped data; 0 for pushes and errors.
REQ-011 rsp_err  output  1  qualifies rsp_valid: push while full or pop while empty.
REQ-012 push, pop  output  1 each  LIFO command strobes, never both high.
REQ-013 din  output  DW  LIFO write data, 0 when push low.
REQ-014 dout  input  DW  LIFO read data, valid the cycle after the pop edge.
REQ-015 empty, full  input  1 each  LIFO status flags.
REQ-016 level  output  $clog2(DEPTH+1)  controller-tracked occupancy.

Function
REQ-017 FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-018 IDLE: no req_valid -> stay; otherwise grant one requester, pulse its req_ready combinationally that cycle, latch id/op/data, go EXEC.
REQ-019 Arbitration round-robin: single valid wins; both valid -> requester at prio pointer wins; pointer moves to the loser after every grant.
REQ-020 EXEC, push, full=0: push=1, din=latched data, level+1, err=0 -> RESP.
REQ-021 EXEC, push, full=1: push=0, level unchanged, err=1 -> RESP.
REQ-022 EXEC, pop, empty=0: pop=1, level-1, err=0 -> RESP.
REQ-023 EXEC, pop, empty=1: pop=0, level unchanged, err=1 -> RESP.
REQ-024 RESP: rsp_valid[id]=1 for exactly one cycle, rsp_data=dout for successful pop else 0, rsp_err=latched err -> IDLE.
REQ-025 Latency: grant to rsp_valid = 2 cycles; max throughput one op per 3 cycles.
REQ-026 empty/full sampled only in EXEC; prior command completed >=2 edges earlier, flags settled.
REQ-027 level saturates at 0 and DEPTH; mismatch with flags is not corrected (flags are authoritative for err).
REQ-028 req_ready low in EXEC and RESP; requests held there wait without loss.
REQ-029 Requester dropping req_valid before grant is legal; nothing issued for it.

Reset
REQ-030 rstn low: state=IDLE, prio=0, level=0, latched id/op/data/err=0.
REQ-031 During reset all outputs 0: req_ready, rsp_valid, rsp_data, rsp_err, push, pop, din.
REQ-032 Reset mid-operation aborts it; no rsp_valid issued for the aborted request after release.
REQ-033 First grant possible on the first rising edge after rstn deasserts.

Structure
REQ-034 Shared package lifo_pkg holds state enum (IDLE/EXEC/RESP), op encodings OP_PUSH/OP_POP, default DW/DEPTH.
REQ-035 One sub-module rr_arb2 (2-way round-robin, pointer register, one-hot grant); FSM and datapath in lifo_arb; instantiates with the existing LIFO in the bench.

Verification
REQ-036 Reset then r0 push 8'h11 -> push=1 with din=8'h11 in EXEC, rsp_valid=2'b01, rsp_err=0, level=1.
REQ-037 r0 pushes 8'h11,8'h22; r1 pop -> rsp_valid=2'b10, rsp_data=8'h22, level=1.
REQ-038 Both valid every cycle, op=push, data r0=8'hA0+n, r1=8'hB0+n -> grants alternate 01,10,01,...; first grant r0.
REQ-039 Push DEPTH=8 values, ninth push 8'hFF -> push stays 0, rsp_err=1, level=8; pop -> rsp_data = eighth value.
REQ-040 Pop from empty after reset -> pop stays 0, rsp_err=1, rsp_data=0, level=0.
REQ-041 Assert rstn low during EXEC of push 8'h33 -> outputs 0 immediately, no rsp_valid after release, next grant to r0.
